// File: rtl/rd_resp_grouper.sv
// Groups in-order read-response beats into 1..NUM_CH-line groups, buffers them in a
// first-word-fall-through FIFO and issues request credits so the buffer cannot overflow.
module rd_resp_grouper #(
   parameter int DATA_W = 512,
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 16
) (
   input  logic                          CLK_400M,
   input  logic                          reset_n,
   input  logic                          clear,
   input  logic [$clog2(NUM_CH):0]       grp_size,
   input  logic                          req_issue,
   output logic                          credit_ok,
   input  logic                          rx_valid,
   input  logic [DATA_W-1:0]             rx_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_CH*DATA_W-1:0]      out_data,
   output logic [NUM_CH-1:0]             out_mask,
   output logic [$clog2(DEPTH):0]        level,
   output logic                          overflow,
   output logic                          err_unexpected
);

   localparam int G_W    = $clog2(NUM_CH) + 1;
   localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int LVL_W  = $clog2(DEPTH) + 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OUT_W  = $clog2(DEPTH * NUM_CH) + 2;
   localparam int CRD_W  = OUT_W + G_W + 2;
   localparam int GD_W   = NUM_CH * DATA_W;
   localparam int ENT_W  = GD_W + NUM_CH;

   logic [LANE_W-1:0] lane_idx;
   logic [G_W-1:0]    g_eff;
   logic [G_W-1:0]    g_clamp;
   logic [G_W-1:0]    g_cur;
   logic [GD_W-1:0]   asm_data;
   logic [GD_W-1:0]   grp_data;
   logic [NUM_CH-1:0] grp_mask;
   logic              last_beat;
   logic              push;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [ENT_W-1:0]  head;
   logic [OUT_W-1:0]  outstanding;
   logic [CRD_W-1:0]  crd_sum;
   logic [CRD_W-1:0]  crd_lim;

   always_comb begin
      g_clamp = grp_size;
      if (grp_size == '0 || grp_size > G_W'(NUM_CH))
         g_clamp = G_W'(NUM_CH);
   end

   // The first beat of a group uses this cycle's size; later beats use the latched one.
   assign g_cur     = (lane_idx == '0) ? g_clamp : g_eff;
   assign last_beat = rx_valid && (G_W'(lane_idx) == g_cur - G_W'(1));

   always_comb begin
      grp_data = '0;
      grp_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (G_W'(i) < g_cur) begin
            grp_mask[i] = 1'b1;
            if (G_W'(i) == G_W'(lane_idx))
               grp_data[i*DATA_W +: DATA_W] = rx_data;
            else
               grp_data[i*DATA_W +: DATA_W] = asm_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output handshake: a group transfers on a cycle where out_valid and out_ready are
   // both high; out_valid never drops and the head entry never changes until then.
   assign out_valid = (level != '0);
   assign pop       = out_valid && out_ready;
   assign fifo_full = (level == LVL_W'(DEPTH));
   assign push      = last_beat && !clear && (!fifo_full || pop);
   assign drop      = last_beat && !clear && fifo_full && !pop;

   assign head     = mem[rd_ptr];
   assign out_data = out_valid ? head[GD_W-1:0] : '0;
   assign out_mask = out_valid ? head[ENT_W-1:GD_W] : '0;

   always_ff @(posedge CLK_400M) begin
      if (rx_valid && !clear && !last_beat)
         asm_data[lane_idx*DATA_W +: DATA_W] <= rx_data;
   end

   always_ff @(posedge CLK_400M) begin
      if (push)
         mem[wr_ptr] <= {grp_mask, grp_data};
   end

   // Credit counts every beat that may still need a FIFO slot, in beats.
   assign crd_sum = CRD_W'(outstanding) + CRD_W'(lane_idx) + CRD_W'(level) * CRD_W'(g_eff);
   assign crd_lim = CRD_W'(DEPTH) * CRD_W'(g_eff);

   always_ff @(posedge CLK_400M or negedge reset_n) begin
      if (!reset_n) begin
         lane_idx       <= '0;
         g_eff          <= G_W'(NUM_CH);
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         outstanding    <= '0;
         overflow       <= 1'b0;
         err_unexpected <= 1'b0;
         credit_ok      <= 1'b1;
      end else if (clear) begin
         lane_idx       <= '0;
         g_eff          <= G_W'(NUM_CH);
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         outstanding    <= '0;
         overflow       <= 1'b0;
         err_unexpected <= 1'b0;
         credit_ok      <= 1'b1;
      end else begin
         if (lane_idx == '0)
            g_eff <= g_clamp;
         if (rx_valid)
            lane_idx <= last_beat ? '0 : lane_idx + LANE_W'(1);
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            level <= level + LVL_W'(1);
         else if (pop && !push)
            level <= level - LVL_W'(1);
         if (drop)
            overflow <= 1'b1;
         if (req_issue && !rx_valid)
            outstanding <= outstanding + OUT_W'(1);
         else if (rx_valid && !req_issue) begin
            if (outstanding == '0)
               err_unexpected <= 1'b1;
            else
               outstanding <= outstanding - OUT_W'(1);
         end
         credit_ok <= (crd_sum < crd_lim);
      end
   end

endmodule

// File: tb/tb_rd_resp_grouper.sv
// Randomised and directed bench for rd_resp_grouper; a queue-based reference model
// predicts groups, buffer level, credit and error flags.
module tb_rd_resp_grouper;

   localparam int DW     = 32;
   localparam int NUM_CH = 2;
   localparam int DEPTH  = 16;
   localparam int GW     = NUM_CH * DW;
   localparam int EW     = GW + NUM_CH;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              clear;
   logic [1:0]        grp_size;
   logic              req_issue;
   logic              credit_ok;
   logic              rx_valid;
   logic [DW-1:0]     rx_data;
   logic              out_valid;
   logic              out_ready;
   logic [GW-1:0]     out_data;
   logic [NUM_CH-1:0] out_mask;
   logic [4:0]        level;
   logic              overflow;
   logic              err_unexpected;

   rd_resp_grouper #(.DATA_W(DW), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
      .CLK_400M(clk), .reset_n(reset_n), .clear(clear), .grp_size(grp_size),
      .req_issue(req_issue), .credit_ok(credit_ok), .rx_valid(rx_valid), .rx_data(rx_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
      .level(level), .overflow(overflow), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit mon_en   = 1'b0;

   // reference model state
   logic [EW-1:0] exp_q[$];
   logic [DW-1:0] part_q[$];
   int part_g   = NUM_CH;
   int m_out    = 0;
   int m_g      = NUM_CH;
   bit m_ovf    = 1'b0;
   bit m_err    = 1'b0;
   bit m_credit = 1'b1;

   task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp(input int gs);
      return (gs == 0 || gs > NUM_CH) ? NUM_CH : gs;
   endfunction

   // One clock cycle: drive inputs, predict the effect of the coming edge, wait for it.
   task automatic cycle(input bit iss, input bit rxv, input logic [DW-1:0] d, input int gs,
                        input bit rdy, input bit clr);
      bit n_push = 1'b0;
      bit n_ovf  = m_ovf;
      bit n_err  = m_err;
      bit n_credit;
      bit pop;
      int lvl;
      logic [EW-1:0] ent = '0;
      req_issue = iss;
      rx_valid  = rxv;
      rx_data   = d;
      grp_size  = gs[1:0];
      out_ready = rdy;
      clear     = clr;
      if (clr) begin
         part_q.delete();
         m_out    = 0;
         m_g      = NUM_CH;
         n_ovf    = 1'b0;
         n_err    = 1'b0;
         n_credit = 1'b1;
      end else begin
         lvl = exp_q.size();
         pop = (lvl != 0) && rdy;
         n_credit = (m_out + part_q.size() + lvl * m_g) < DEPTH * m_g;
         if (part_q.size() == 0)
            m_g = clamp(gs);
         if (rxv) begin
            if (part_q.size() == 0)
               part_g = clamp(gs);
            part_q.push_back(d);
            if (part_q.size() == part_g) begin
               for (int i = 0; i < part_g; i++) begin
                  ent[i*DW +: DW] = part_q[i];
                  ent[GW + i]     = 1'b1;
               end
               if (lvl < DEPTH || pop)
                  n_push = 1'b1;
               else
                  n_ovf = 1'b1;
               part_q.delete();
            end
         end
         if (iss && !rxv)
            m_out++;
         else if (rxv && !iss) begin
            if (m_out == 0)
               n_err = 1'b1;
            else
               m_out--;
         end
      end
      @(posedge clk);
      #1;
      if (clr)
         exp_q.delete();
      if (n_push)
         exp_q.push_back(ent);
      m_ovf    = n_ovf;
      m_err    = n_err;
      m_credit = n_credit;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, '0, NUM_CH, rdy, 1'b0);
   endtask

   task automatic issue_n(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 1'b0, '0, NUM_CH, 1'b0, 1'b0);
   endtask

   task automatic beats_n(input int n, input int gs, input bit rdy);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b1, DW'($urandom), gs, rdy, 1'b0);
   endtask

   task automatic do_clear();
      cycle(1'b0, 1'b0, '0, NUM_CH, 1'b0, 1'b1);
   endtask

   // Monitor: compare outputs against the model every cycle, retire groups on handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", GW'(out_valid), GW'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0][GW-1:0]);
            chk("out_mask", GW'(out_mask), GW'(exp_q[0][EW-1:GW]));
         end
         chk("level", GW'(level), GW'(exp_q.size()));
         chk("overflow", GW'(overflow), GW'(m_ovf));
         chk("err_unexpected", GW'(err_unexpected), GW'(m_err));
         chk("credit_ok", GW'(credit_ok), GW'(m_credit));
         if (exp_q.size() != 0 && out_ready && !clear)
            void'(exp_q.pop_front());
      end
   end

   initial begin
      int guard;
      reset_n = 1'b0; clear = 1'b0; grp_size = '0; req_issue = 1'b0;
      rx_valid = 1'b0; rx_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst out_valid", GW'(out_valid), '0);
      chk("rst out_data", out_data, '0);
      chk("rst out_mask", GW'(out_mask), '0);
      chk("rst level", GW'(level), '0);
      chk("rst overflow", GW'(overflow), '0);
      chk("rst err", GW'(err_unexpected), '0);
      chk("rst credit_ok", GW'(credit_ok), GW'(1));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // two full groups back to back
      issue_n(4);
      beats_n(4, 2, 1'b1);
      idle(3, 1'b1);

      // size 1 group, then a size 2 group whose size input changes mid-group
      issue_n(3);
      beats_n(1, 1, 1'b1);
      cycle(1'b0, 1'b1, DW'($urandom), 2, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, DW'($urandom), 1, 1'b1, 1'b0);
      idle(3, 1'b1);

      // fill the buffer using credit, then release one slot
      do_clear();
      guard = 0;
      while (credit_ok && guard < 100) begin
         cycle(1'b1, 1'b0, '0, 2, 1'b0, 1'b0);
         guard++;
      end
      chk("credit fell", GW'(guard < 100), GW'(1));
      beats_n(m_out, 2, 1'b0);
      idle(3, 1'b0);
      idle(1, 1'b1);
      idle(3, 1'b0);

      // forced beats beyond credit with no pop: one group dropped
      issue_n(3);
      beats_n(3, 2, 1'b0);
      idle(2, 1'b0);

      // full buffer, but the final beat lands together with a pop
      do_clear();
      issue_n(DEPTH * 2 + 2);
      beats_n(DEPTH * 2 + 1, 2, 1'b0);
      beats_n(1, 2, 1'b1);
      idle(2, 1'b0);
      idle(DEPTH + 2, 1'b1);

      // response without a request
      do_clear();
      beats_n(1, 2, 1'b1);
      idle(2, 1'b1);

      // clear in the middle of a group; the beat in the clear cycle is dropped
      do_clear();
      issue_n(3);
      issue_n(1);
      beats_n(1, 2, 1'b1);
      cycle(1'b0, 1'b1, DW'($urandom), 2, 1'b1, 1'b1);
      issue_n(2);
      beats_n(2, 2, 1'b1);
      idle(3, 1'b1);

      // random traffic honouring credit
      for (int i = 0; i < 1500; i++) begin
         bit iss;
         bit rxv;
         iss = credit_ok && ($urandom_range(0, 3) != 0);
         rxv = (m_out > 0) && ($urandom_range(0, 3) != 0);
         cycle(iss, rxv, DW'($urandom), int'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      end
      idle(DEPTH + 4, 1'b1);

      // asynchronous reset with a group held in the buffer
      do_clear();
      issue_n(2);
      beats_n(2, 2, 1'b0);
      mon_en = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async out_valid", GW'(out_valid), '0);
      chk("async level", GW'(level), '0);
      chk("async credit_ok", GW'(credit_ok), GW'(1));
      chk("async out_data", out_data, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
